// File: rtl/mult_64_arbiter.sv
// Two-requester round-robin arbiter in front of one pipelined 32x32->64 multiplier.
// Define MULT_ARB_FIXED_PRIORITY_EN to make requester 0 win every tie.
module mult_64_arbiter #(
  parameter int TAG_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] req0_a_tdata,
  input  logic [31:0] req0_b_tdata,
  input  logic        req0_tvalid,
  output logic        req0_tready,
  input  logic [31:0] req1_a_tdata,
  input  logic [31:0] req1_b_tdata,
  input  logic        req1_tvalid,
  output logic        req1_tready,
  output logic [63:0] res0_tdata,
  output logic        res0_tvalid,
  input  logic        res0_tready,
  output logic [63:0] res1_tdata,
  output logic        res1_tvalid,
  input  logic        res1_tready,
  output logic [31:0] mul_a_tdata,
  output logic        mul_a_tvalid,
  input  logic        mul_a_tready,
  output logic [31:0] mul_b_tdata,
  output logic        mul_b_tvalid,
  input  logic        mul_b_tready,
  input  logic [63:0] mul_out_tdata,
  input  logic        mul_out_tvalid,
  output logic        mul_out_tready
);

  localparam int PTR_W = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
  localparam int CNT_W = $clog2(TAG_DEPTH + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_t;

  state_t           state;
  logic             tag_mem [TAG_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             a_done;
  logic             b_done;

  logic             can_accept;
  logic             grant0;
  logic             grant1;
  logic             push;
  logic             pop;
  logic             empty;
  logic             head;
  logic             a_hs;
  logic             b_hs;
  logic             issue_done;

`ifndef MULT_ARB_FIXED_PRIORITY_EN
  // 1 means requester 1 was granted last, so requester 0 wins the next tie
  logic             last_grant;
`endif

  assign can_accept = (state == IDLE) && (count < CNT_W'(TAG_DEPTH));

  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (can_accept) begin
`ifdef MULT_ARB_FIXED_PRIORITY_EN
      grant0 = req0_tvalid;
      grant1 = req1_tvalid && !req0_tvalid;
`else
      grant0 = req0_tvalid && (!req1_tvalid || last_grant);
      grant1 = req1_tvalid && !grant0;
`endif
    end
  end

  assign req0_tready = grant0;
  assign req1_tready = grant1;
  assign push        = grant0 || grant1;

  // Return path is purely combinational, steered by the oldest outstanding tag
  assign empty          = (count == '0);
  assign head           = tag_mem[rd_ptr];
  assign res0_tdata     = mul_out_tdata;
  assign res1_tdata     = mul_out_tdata;
  assign res0_tvalid    = mul_out_tvalid && !empty && !head;
  assign res1_tvalid    = mul_out_tvalid && !empty && head;
  assign mul_out_tready = !empty && (head ? res1_tready : res0_tready);
  assign pop            = mul_out_tvalid && mul_out_tready;

  assign a_hs       = mul_a_tvalid && mul_a_tready;
  assign b_hs       = mul_b_tvalid && mul_b_tready;
  assign issue_done = (state == ISSUE) && (a_done || a_hs) && (b_done || b_hs);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      mul_a_tdata  <= '0;
      mul_b_tdata  <= '0;
      mul_a_tvalid <= 1'b0;
      mul_b_tvalid <= 1'b0;
      a_done       <= 1'b0;
      b_done       <= 1'b0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      for (int i = 0; i < TAG_DEPTH; i++) tag_mem[i] <= 1'b0;
`ifndef MULT_ARB_FIXED_PRIORITY_EN
      last_grant   <= 1'b1;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (push) begin
            mul_a_tdata     <= grant1 ? req1_a_tdata : req0_a_tdata;
            mul_b_tdata     <= grant1 ? req1_b_tdata : req0_b_tdata;
            mul_a_tvalid    <= 1'b1;
            mul_b_tvalid    <= 1'b1;
            a_done          <= 1'b0;
            b_done          <= 1'b0;
            tag_mem[wr_ptr] <= grant1;
            wr_ptr          <= wr_ptr + PTR_W'(1);
`ifndef MULT_ARB_FIXED_PRIORITY_EN
            last_grant      <= grant1;
`endif
            state           <= ISSUE;
          end
        end
        ISSUE: begin
          // Each operand lane retires independently; leave once both have gone
          if (a_hs) begin
            mul_a_tvalid <= 1'b0;
            a_done       <= 1'b1;
          end
          if (b_hs) begin
            mul_b_tvalid <= 1'b0;
            b_done       <= 1'b1;
          end
          if (issue_done) state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);

      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_64_arbiter.sv
// Scoreboard bench for mult_64_arbiter with a latency-2 multiplier model.
// Honours MULT_ARB_FIXED_PRIORITY_EN for the expected grant order.
module tb_mult_64_arbiter;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
  } vec_t;

  typedef struct {
    logic [63:0] p;
    int          rdy;
  } prod_t;

  logic        clk;
  logic        rst;
  logic [31:0] req0_a_tdata, req0_b_tdata, req1_a_tdata, req1_b_tdata;
  logic        req0_tvalid, req0_tready, req1_tvalid, req1_tready;
  logic [63:0] res0_tdata, res1_tdata;
  logic        res0_tvalid, res0_tready, res1_tvalid, res1_tready;
  logic [31:0] mul_a_tdata, mul_b_tdata;
  logic        mul_a_tvalid, mul_a_tready, mul_b_tvalid, mul_b_tready;
  logic [63:0] mul_out_tdata;
  logic        mul_out_tvalid, mul_out_tready;

  int checks = 0;
  int errors = 0;

  vec_t        stim0[$];
  vec_t        stim1[$];
  logic [63:0] exp0[$];
  logic [63:0] exp1[$];
  int          grant_log[$];
  prod_t       prod_q[$];
  int          acc0 = 0;
  int          acc1 = 0;
  int          cyc = 0;
  logic        got_a, got_b;
  logic [31:0] val_a, val_b;

  mult_64_arbiter #(.TAG_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .req0_a_tdata(req0_a_tdata), .req0_b_tdata(req0_b_tdata),
    .req0_tvalid(req0_tvalid), .req0_tready(req0_tready),
    .req1_a_tdata(req1_a_tdata), .req1_b_tdata(req1_b_tdata),
    .req1_tvalid(req1_tvalid), .req1_tready(req1_tready),
    .res0_tdata(res0_tdata), .res0_tvalid(res0_tvalid), .res0_tready(res0_tready),
    .res1_tdata(res1_tdata), .res1_tvalid(res1_tvalid), .res1_tready(res1_tready),
    .mul_a_tdata(mul_a_tdata), .mul_a_tvalid(mul_a_tvalid), .mul_a_tready(mul_a_tready),
    .mul_b_tdata(mul_b_tdata), .mul_b_tvalid(mul_b_tvalid), .mul_b_tready(mul_b_tready),
    .mul_out_tdata(mul_out_tdata), .mul_out_tvalid(mul_out_tvalid),
    .mul_out_tready(mul_out_tready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input int port, input logic [31:0] a,
                               input logic [31:0] b, input logic [63:0] exp);
    vec_t v;
    v.a = a;
    v.b = b;
    v.exp = exp;
    if (port == 0) stim0.push_back(v);
    else stim1.push_back(v);
  endtask

  task automatic waitSample();
    @(negedge clk);
    #1;
  endtask

  task automatic waitDrain(input string name);
    int n;
    n = 0;
    while ((stim0.size() + stim1.size() + exp0.size() + exp1.size() + prod_q.size()) != 0
           && n < 300) begin
      waitSample();
      n++;
    end
    if (n >= 300) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s: drain timeout, %0d results outstanding", name,
               exp0.size() + exp1.size());
    end
  endtask

  // Requester drivers: present the queue front until the arbiter takes it
  always @(negedge clk) begin
    req0_tvalid  = rst && (stim0.size() > 0);
    req0_a_tdata = req0_tvalid ? stim0[0].a : '0;
    req0_b_tdata = req0_tvalid ? stim0[0].b : '0;
    req1_tvalid  = rst && (stim1.size() > 0);
    req1_a_tdata = req1_tvalid ? stim1[0].a : '0;
    req1_b_tdata = req1_tvalid ? stim1[0].b : '0;
  end

  // Multiplier model: latches each operand lane on its own handshake
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      prod_q.delete();
      got_a = 1'b0;
      got_b = 1'b0;
      val_a = '0;
      val_b = '0;
    end else begin
      cyc++;
      if (mul_out_tvalid && mul_out_tready && prod_q.size() > 0) void'(prod_q.pop_front());
      if (mul_a_tvalid && mul_a_tready) begin
        got_a = 1'b1;
        val_a = mul_a_tdata;
      end
      if (mul_b_tvalid && mul_b_tready) begin
        got_b = 1'b1;
        val_b = mul_b_tdata;
      end
      if (got_a && got_b) begin
        prod_t p;
        p.p = {32'd0, val_a} * {32'd0, val_b};
        p.rdy = cyc + 2;
        prod_q.push_back(p);
        got_a = 1'b0;
        got_b = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    mul_out_tvalid = (prod_q.size() > 0) && (prod_q[0].rdy <= cyc);
    mul_out_tdata  = mul_out_tvalid ? prod_q[0].p : '0;
  end

  // Issue side pushes expectations; result side pops and compares
  always @(posedge clk) begin
    if (rst) begin
      if (req0_tvalid && req0_tready && stim0.size() > 0) begin
        exp0.push_back(stim0[0].exp);
        void'(stim0.pop_front());
        grant_log.push_back(0);
        acc0++;
      end
      if (req1_tvalid && req1_tready && stim1.size() > 0) begin
        exp1.push_back(stim1[0].exp);
        void'(stim1.pop_front());
        grant_log.push_back(1);
        acc1++;
      end
      if (res0_tvalid) begin
        if (exp0.size() == 0) checkOutput("res0_unexpected_valid", 64'd1, 64'd0);
        else if (res0_tready) checkOutput("res0_tdata", res0_tdata, exp0.pop_front());
      end
      if (res1_tvalid) begin
        if (exp1.size() == 0) checkOutput("res1_unexpected_valid", 64'd1, 64'd0);
        else if (res1_tready) checkOutput("res1_tdata", res1_tdata, exp1.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int base;
    int n;
    int exp_grants[6];
`ifdef MULT_ARB_FIXED_PRIORITY_EN
    exp_grants = '{0, 0, 0, 1, 1, 1};
`else
    exp_grants = '{0, 1, 0, 1, 0, 1};
`endif
    rst = 1'b0;
    req0_tvalid = 1'b0; req1_tvalid = 1'b0;
    req0_a_tdata = '0; req0_b_tdata = '0; req1_a_tdata = '0; req1_b_tdata = '0;
    mul_a_tready = 1'b1; mul_b_tready = 1'b1;
    res0_tready = 1'b1; res1_tready = 1'b1;
    mul_out_tvalid = 1'b0; mul_out_tdata = '0;

    repeat (3) waitSample();
    checkOutput("reset_mul_a_tvalid", {63'd0, mul_a_tvalid}, 64'd0);
    checkOutput("reset_mul_b_tvalid", {63'd0, mul_b_tvalid}, 64'd0);
    checkOutput("reset_mul_a_tdata", {32'd0, mul_a_tdata}, 64'd0);
    checkOutput("reset_mul_b_tdata", {32'd0, mul_b_tdata}, 64'd0);
    checkOutput("reset_mul_out_tready", {63'd0, mul_out_tready}, 64'd0);
    checkOutput("reset_res0_tvalid", {63'd0, res0_tvalid}, 64'd0);
    checkOutput("reset_res1_tvalid", {63'd0, res1_tvalid}, 64'd0);
    rst = 1'b1;
    waitSample();

    $display("[TB] single op");
    applyStimulus(0, 32'd3, 32'd5, 64'd15);
    waitDrain("single_op");

    $display("[TB] max operands");
    applyStimulus(1, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001);
    waitDrain("max_operands");

    $display("[TB] full FIFO");
    res0_tready = 1'b0;
    res1_tready = 1'b0;
    base = acc0;
    applyStimulus(0, 32'd2, 32'd3, 64'd6);
    applyStimulus(0, 32'd4, 32'd5, 64'd20);
    applyStimulus(0, 32'd6, 32'd7, 64'd42);
    applyStimulus(0, 32'd8, 32'd9, 64'd72);
    applyStimulus(0, 32'd10, 32'd11, 64'd110);
    repeat (16) waitSample();
    checkOutput("full_accepted", 64'(acc0 - base), 64'd4);
    checkOutput("full_req0_tready", {63'd0, req0_tready}, 64'd0);
    res0_tready = 1'b1;
    waitSample();
    res0_tready = 1'b0;
    checkOutput("after_pop_req0_tready", {63'd0, req0_tready}, 64'd1);
    waitSample();
    checkOutput("after_pop_accepted", 64'(acc0 - base), 64'd5);
    res0_tready = 1'b1;
    res1_tready = 1'b1;
    waitDrain("full_fifo");

    $display("[TB] split handshake");
    mul_b_tready = 1'b0;
    applyStimulus(0, 32'd7, 32'd9, 64'd63);
    n = 0;
    while (!mul_b_tvalid && n < 10) begin
      waitSample();
      n++;
    end
    checkOutput("split_issue_seen", {63'd0, mul_b_tvalid}, 64'd1);
    checkOutput("split_a_tdata", {32'd0, mul_a_tdata}, 64'd7);
    for (int i = 0; i < 3; i++) begin
      waitSample();
      checkOutput($sformatf("split_a_dropped_%0d", i), {63'd0, mul_a_tvalid}, 64'd0);
      checkOutput($sformatf("split_b_held_%0d", i), {63'd0, mul_b_tvalid}, 64'd1);
      checkOutput($sformatf("split_b_tdata_%0d", i), {32'd0, mul_b_tdata}, 64'd9);
    end
    mul_b_tready = 1'b1;
    waitSample();
    checkOutput("split_b_dropped", {63'd0, mul_b_tvalid}, 64'd0);
    waitDrain("split_handshake");

    $display("[TB] reset mid-flight");
    res0_tready = 1'b0;
    res1_tready = 1'b0;
    applyStimulus(0, 32'd11, 32'd13, 64'd143);
    applyStimulus(1, 32'd17, 32'd19, 64'd323);
    repeat (12) waitSample();
    checkOutput("inflight_count", 64'(dut.count), 64'd2);
    res0_tready = 1'b1;
    res1_tready = 1'b1;
    rst = 1'b0;
    exp0.delete();
    exp1.delete();
    #1;
    checkOutput("rst_count", 64'(dut.count), 64'd0);
    checkOutput("rst_mul_out_tready", {63'd0, mul_out_tready}, 64'd0);
    checkOutput("rst_res0_tvalid", {63'd0, res0_tvalid}, 64'd0);
    checkOutput("rst_res1_tvalid", {63'd0, res1_tvalid}, 64'd0);
    checkOutput("rst_mul_a_tvalid", {63'd0, mul_a_tvalid}, 64'd0);
    checkOutput("rst_mul_b_tvalid", {63'd0, mul_b_tvalid}, 64'd0);
    checkOutput("rst_mul_a_tdata", {32'd0, mul_a_tdata}, 64'd0);
    repeat (2) waitSample();
    rst = 1'b1;
    waitSample();

    $display("[TB] contention");
    grant_log.delete();
    applyStimulus(0, 32'd100, 32'd200, 64'd20000);
    applyStimulus(0, 32'd0, 32'd12345, 64'd0);
    applyStimulus(0, 32'd65536, 32'd65536, 64'h100000000);
    applyStimulus(1, 32'd1000, 32'd1000, 64'd1000000);
    applyStimulus(1, 32'h80000000, 32'd2, 64'h100000000);
    applyStimulus(1, 32'hDEADBEEF, 32'd1, 64'hDEADBEEF);
    waitDrain("contention");
    checkOutput("grant_count", 64'(grant_log.size()), 64'd6);
    for (int i = 0; i < 6; i++) begin
      checkOutput($sformatf("grant_%0d", i),
                  (i < grant_log.size()) ? 64'(grant_log[i]) : 64'd2, 64'(exp_grants[i]));
    end

    checkOutput("scoreboard_empty", 64'(exp0.size() + exp1.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
